// File: rtl/motor_pkg.sv
// motor_pkg
//   Shared definitions for the quadrature decoder slice:
//     - DEFAULT_FILT_LEN : default glitch-filter length in cclk cycles
//     - Q00/Q10/Q11/Q01  : quadrature state encodings, written as {A,B}
//     - dec_state_t      : decoder FSM states
//     - move_t           : classification of one filtered {A,B} change
//     - fwd_next/classify: helpers that decode quadrature transitions
package motor_pkg;

    localparam int DEFAULT_FILT_LEN = 4;

    localparam logic [1:0] Q00 = 2'b00;
    localparam logic [1:0] Q10 = 2'b10;
    localparam logic [1:0] Q11 = 2'b11;
    localparam logic [1:0] Q01 = 2'b01;

    typedef enum logic {
        UNINIT,
        TRACK
    } dec_state_t;

    typedef enum logic [1:0] {
        MOVE_NONE,
        MOVE_FWD,
        MOVE_REV,
        MOVE_ILLEGAL
    } move_t;

    // Forward order is 00 -> 10 -> 11 -> 01 -> 00, i.e. A leads B.
    function automatic logic [1:0] fwd_next(input logic [1:0] q);
        logic [1:0] n;
        case (q)
            Q00:     n = Q10;
            Q10:     n = Q11;
            Q11:     n = Q01;
            default: n = Q00;
        endcase
        return n;
    endfunction

    // A one-step move forward or backward is legal; a change of both bits
    // at once cannot be attributed to a direction and is flagged illegal.
    function automatic move_t classify(input logic [1:0] prev, input logic [1:0] cur);
        move_t m;
        if (cur == prev)
            m = MOVE_NONE;
        else if (cur == fwd_next(prev))
            m = MOVE_FWD;
        else if (prev == fwd_next(cur))
            m = MOVE_REV;
        else
            m = MOVE_ILLEGAL;
        return m;
    endfunction

endpackage

// File: rtl/input_filter.sv
// input_filter
//   Two-flop synchronizer followed by a glitch filter for one raw encoder
//   channel. The filtered value only follows the synchronized value after
//   the two have disagreed for FILT_LEN consecutive cclk cycles.
//
//   Ports:
//     cclk    in   system clock
//     rstb    in   synchronous active-low reset
//     raw     in   raw channel, asynchronous to cclk
//     filt    out  filtered, cclk-synchronous channel value
//     settled out  synchronizer primed, filter agrees with input, counter idle
module input_filter
    import motor_pkg::*;
#(
    parameter int FILT_LEN = DEFAULT_FILT_LEN
) (
    input  logic cclk,
    input  logic rstb,
    input  logic raw,
    output logic filt,
    output logic settled
);

    localparam logic [7:0] CNT_LAST = 8'(FILT_LEN - 1);

    logic       sync1;
    logic       sync2;
    logic [7:0] cnt;
    logic [1:0] primed;

    // primed marks when sync2 holds a real sample rather than its reset
    // value, so the decoder does not latch a stale 0 right after reset.
    always_ff @(posedge cclk) begin
        if (!rstb) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            filt   <= 1'b0;
            cnt    <= 8'd0;
            primed <= 2'b00;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            primed <= {primed[0], 1'b1};
            if (sync2 == filt) begin
                cnt <= 8'd0;
            end else if (cnt == CNT_LAST) begin
                filt <= sync2;
                cnt  <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign settled = primed[1] && (sync2 == filt) && (cnt == 8'd0);

endmodule

// File: rtl/quadrature_decoder.sv
// quadrature_decoder
//   Decodes a two-channel quadrature encoder into step/direction pulses and
//   a signed position count, flags illegal double-bit jumps, and provides a
//   clean per-revolution tick derived from filtered channel A.
//
//   Ports:
//     cclk     in   system clock
//     rstb     in   synchronous active-low reset
//     a, b     in   raw encoder channels (asynchronous)
//     clr_pos  in   synchronous clear of pos (wins over a same-cycle step)
//     err_clr  in   synchronous clear of err (loses to a same-cycle error)
//     step     out  one-cycle pulse per legal transition
//     dir      out  direction of last legal transition, 1 = reverse
//     rev_tick out  one-cycle pulse on each filtered A rising edge
//     pos      out  POS_W-bit two's-complement position, wraps freely
//     err      out  sticky illegal-transition flag
module quadrature_decoder
    import motor_pkg::*;
#(
    parameter int FILT_LEN = DEFAULT_FILT_LEN,
    parameter int POS_W    = 16
) (
    input  logic             cclk,
    input  logic             rstb,
    input  logic             a,
    input  logic             b,
    input  logic             clr_pos,
    input  logic             err_clr,
    output logic             step,
    output logic             dir,
    output logic             rev_tick,
    output logic [POS_W-1:0] pos,
    output logic             err
);

    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    logic       a_f;
    logic       b_f;
    logic       a_settled;
    logic       b_settled;
    logic [1:0] cur;
    logic [1:0] prev_q;

    dec_state_t state_q;
    dec_state_t state_d;

    logic             step_d;
    logic             dir_d;
    logic             rev_d;
    logic [POS_W-1:0] pos_d;
    logic             err_d;
    logic [1:0]       prev_d;
    move_t            move;

    input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .cclk    (cclk),
        .rstb    (rstb),
        .raw     (a),
        .filt    (a_f),
        .settled (a_settled)
    );

    input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .cclk    (cclk),
        .rstb    (rstb),
        .raw     (b),
        .filt    (b_f),
        .settled (b_settled)
    );

    assign cur = {a_f, b_f};

    always_ff @(posedge cclk) begin
        if (!rstb)
            state_q <= UNINIT;
        else
            state_q <= state_d;
    end

    // Tracking starts only once both channels are settled, so the first
    // recorded quadrature state reflects the real encoder position.
    always_comb begin
        state_d = state_q;
        case (state_q)
            UNINIT:  if (a_settled && b_settled) state_d = TRACK;
            default: state_d = TRACK;
        endcase
    end

    // err_clr is applied before the illegal-move check so a coincident
    // error sets the flag; clr_pos is applied last so it beats a step.
    always_comb begin
        step_d = 1'b0;
        dir_d  = dir;
        rev_d  = 1'b0;
        pos_d  = pos;
        err_d  = err;
        prev_d = prev_q;
        move   = classify(prev_q, cur);

        if (err_clr)
            err_d = 1'b0;

        case (state_q)
            UNINIT: begin
                if (a_settled && b_settled)
                    prev_d = cur;
            end
            default: begin
                prev_d = cur;
                rev_d  = !prev_q[1] && cur[1];
                case (move)
                    MOVE_FWD: begin
                        step_d = 1'b1;
                        dir_d  = 1'b0;
                        pos_d  = pos + POS_ONE;
                    end
                    MOVE_REV: begin
                        step_d = 1'b1;
                        dir_d  = 1'b1;
                        pos_d  = pos - POS_ONE;
                    end
                    MOVE_ILLEGAL: err_d = 1'b1;
                    default: ;
                endcase
            end
        endcase

        if (clr_pos)
            pos_d = '0;
    end

    always_ff @(posedge cclk) begin
        if (!rstb) begin
            step     <= 1'b0;
            dir      <= 1'b0;
            rev_tick <= 1'b0;
            pos      <= '0;
            err      <= 1'b0;
            prev_q   <= Q00;
        end else begin
            step     <= step_d;
            dir      <= dir_d;
            rev_tick <= rev_d;
            pos      <= pos_d;
            err      <= err_d;
            prev_q   <= prev_d;
        end
    end

endmodule

// File: tb/tb_quadrature_decoder.sv
// tb_quadrature_decoder
//   Directed self-checking bench for quadrature_decoder with FILT_LEN=4,
//   POS_W=16. Inputs change 1ns after a rising edge; outputs are sampled
//   at the same point, and pulse outputs are tallied on falling edges.
module tb_quadrature_decoder;

    logic        cclk;
    logic        rstb;
    logic        a;
    logic        b;
    logic        clr_pos;
    logic        err_clr;
    logic        step;
    logic        dir;
    logic        rev_tick;
    logic [15:0] pos;
    logic        err;

    int total_cnt;
    int bad_cnt;
    int step_cnt;
    int rev_cnt;
    int step_base;
    int rev_base;
    int first_edge;

    quadrature_decoder #(.FILT_LEN(4), .POS_W(16)) dut (
        .cclk     (cclk),
        .rstb     (rstb),
        .a        (a),
        .b        (b),
        .clr_pos  (clr_pos),
        .err_clr  (err_clr),
        .step     (step),
        .dir      (dir),
        .rev_tick (rev_tick),
        .pos      (pos),
        .err      (err)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    // Pulse counters for step and rev_tick.
    always @(negedge cclk) begin
        if (rstb === 1'b1) begin
            if (step === 1'b1) step_cnt++;
            if (rev_tick === 1'b1) rev_cnt++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge cclk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic av, input logic bv);
        a = av;
        b = bv;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual !== expected) begin
            bad_cnt++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", tag, actual, expected);
        end
    endtask

    task automatic markCounts();
        step_base = step_cnt;
        rev_base  = rev_cnt;
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        step_cnt  = 0;
        rev_cnt   = 0;
        rstb      = 1'b0;
        clr_pos   = 1'b0;
        err_clr   = 1'b0;
        applyStimulus(1'b1, 1'b1);

        // Reset with a=b=1 held, then release: should load 11 silently.
        tick(3);
        checkOutput("rst_step", 32'(step), 32'h0);
        checkOutput("rst_dir", 32'(dir), 32'h0);
        checkOutput("rst_rev", 32'(rev_tick), 32'h0);
        checkOutput("rst_pos", 32'(pos), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        rstb = 1'b1;
        markCounts();
        tick(30);
        checkOutput("init11_steps", 32'(step_cnt - step_base), 32'h0);
        checkOutput("init11_err", 32'(err), 32'h0);
        checkOutput("init11_pos", 32'(pos), 32'h0);
        // 11 -> 01 is a forward move only if 11 was loaded.
        applyStimulus(1'b0, 1'b1);
        tick(20);
        checkOutput("init11_fwd_pos", 32'(pos), 32'h1);
        checkOutput("init11_fwd_err", 32'(err), 32'h0);
        checkOutput("init11_fwd_steps", 32'(step_cnt - step_base), 32'h1);

        // Reset arriving mid-filter discards the partial edge.
        applyStimulus(1'b0, 1'b0);
        tick(20);
        applyStimulus(1'b1, 1'b0);
        tick(4);
        rstb = 1'b0;
        applyStimulus(1'b0, 1'b0);
        tick(2);
        rstb = 1'b1;
        markCounts();
        tick(20);
        checkOutput("midrst_steps", 32'(step_cnt - step_base), 32'h0);
        checkOutput("midrst_pos", 32'(pos), 32'h0);

        // Ten forward cycles, each level held 20 cycles, first-step latency.
        markCounts();
        first_edge = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            for (int ph = 0; ph < 4; ph++) begin
                case (ph)
                    0: applyStimulus(1'b1, 1'b0);
                    1: applyStimulus(1'b1, 1'b1);
                    2: applyStimulus(1'b0, 1'b1);
                    default: applyStimulus(1'b0, 1'b0);
                endcase
                for (int k = 1; k <= 20; k++) begin
                    tick(1);
                    if (cyc == 0 && ph == 0 && first_edge == 0 && step === 1'b1)
                        first_edge = k;
                end
            end
        end
        checkOutput("fwd_latency", 32'(first_edge), 32'd7);
        checkOutput("fwd_steps", 32'(step_cnt - step_base), 32'd40);
        checkOutput("fwd_revs", 32'(rev_cnt - rev_base), 32'd10);
        checkOutput("fwd_pos", 32'(pos), 32'd40);
        checkOutput("fwd_dir", 32'(dir), 32'h0);
        checkOutput("fwd_err", 32'(err), 32'h0);

        // 3-cycle glitch on a is swallowed.
        markCounts();
        applyStimulus(1'b1, 1'b0);
        tick(3);
        applyStimulus(1'b0, 1'b0);
        tick(20);
        checkOutput("glitch3_steps", 32'(step_cnt - step_base), 32'h0);
        checkOutput("glitch3_revs", 32'(rev_cnt - rev_base), 32'h0);
        checkOutput("glitch3_pos", 32'(pos), 32'd40);

        // 4-cycle pulse just passes: forward then reverse.
        markCounts();
        applyStimulus(1'b1, 1'b0);
        tick(4);
        applyStimulus(1'b0, 1'b0);
        tick(20);
        checkOutput("pulse4_steps", 32'(step_cnt - step_base), 32'd2);
        checkOutput("pulse4_revs", 32'(rev_cnt - rev_base), 32'd1);
        checkOutput("pulse4_pos", 32'(pos), 32'd40);
        checkOutput("pulse4_dir", 32'(dir), 32'h1);

        // Clear, then wrap below zero and back.
        clr_pos = 1'b1;
        tick(1);
        clr_pos = 1'b0;
        checkOutput("clr_pos", 32'(pos), 32'h0);
        applyStimulus(1'b0, 1'b1);
        tick(20);
        checkOutput("wrap_rev_pos", 32'(pos), 32'hFFFF);
        checkOutput("wrap_rev_dir", 32'(dir), 32'h1);
        applyStimulus(1'b0, 1'b0);
        tick(20);
        checkOutput("wrap_fwd_pos", 32'(pos), 32'h0);
        checkOutput("wrap_fwd_dir", 32'(dir), 32'h0);

        // Illegal jump 00 -> 11, err clear, then clear racing a new jump.
        markCounts();
        applyStimulus(1'b1, 1'b1);
        tick(20);
        checkOutput("illegal_err", 32'(err), 32'h1);
        checkOutput("illegal_pos", 32'(pos), 32'h0);
        checkOutput("illegal_steps", 32'(step_cnt - step_base), 32'h0);
        checkOutput("illegal_revs", 32'(rev_cnt - rev_base), 32'h1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        checkOutput("errclr", 32'(err), 32'h0);
        applyStimulus(1'b0, 1'b0);
        err_clr = 1'b1;
        tick(6);
        checkOutput("errclr_pre", 32'(err), 32'h0);
        tick(1);
        checkOutput("errclr_setwins", 32'(err), 32'h1);
        err_clr = 1'b0;
        tick(13);
        checkOutput("err_sticky", 32'(err), 32'h1);
        checkOutput("err_pos", 32'(pos), 32'h0);

        // clr_pos coincident with a reverse step.
        applyStimulus(1'b1, 1'b0);
        tick(20);
        checkOutput("pre_clr_pos", 32'(pos), 32'h1);
        applyStimulus(1'b0, 1'b0);
        tick(6);
        clr_pos = 1'b1;
        tick(1);
        clr_pos = 1'b0;
        checkOutput("clrstep_step", 32'(step), 32'h1);
        checkOutput("clrstep_pos", 32'(pos), 32'h0);
        checkOutput("clrstep_dir", 32'(dir), 32'h1);
        tick(1);
        checkOutput("clrstep_after_step", 32'(step), 32'h0);
        checkOutput("clrstep_after_pos", 32'(pos), 32'h0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/quadrature_decoder.md
QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 Parameter FILT_LEN, default 4: number of consecutive cclk cycles a synchronized input must differ from its filtered value before the filtered value changes; legal range 1..255.
REQ-002 Parameter POS_W, default 16: width of the position counter.
REQ-003 cclk  input  1  system clock; all state updates on rising edge.
REQ-004 rstb  input  1  reset: synchronous, active-low.
REQ-005 a  input  1  raw encoder channel A, asynchronous to cclk.
REQ-006 b  input  1  raw encoder channel B, asynchronous to cclk.
REQ-007 clr_pos  input  1  synchronous clear of pos, level-sampled each cycle.
REQ-008 err_clr  input  1  synchronous clear of err.
REQ-009 step  output  1  one-cycle pulse per legal quadrature transition.
REQ-010 dir  output  1  direction of last legal transition; 0 = forward (A leads B), 1 = reverse.
REQ-011 rev_tick  output  1  one-cycle pulse on each rising edge of filtered A; clean, cclk-synchronous replacement for raw A in downstream rev counting.
REQ-012 pos  output  POS_W  signed two's-complement position count.
REQ-013 err  output  1  sticky flag for an illegal (double-bit) transition.

Function
REQ-014 Each raw input SHALL pass through a 2-flop synchronizer, then a glitch filter with a per-channel counter.
REQ-015 Filter counter SHALL reset to 0 in any cycle where the synchronized value equals the filtered value; otherwise it increments, and the filtered value takes the synchronized value on the cycle the counter reaches FILT_LEN.
REQ-016 Pulses shorter than FILT_LEN cycles at the synchronizer output SHALL produce no change in filtered value, step, rev_tick, pos or err.
REQ-017 Decoder SHALL have two states: UNINIT (after reset) and TRACK.
REQ-018 UNINIT: first cycle with both filters settled (both counters 0 for one cycle after reset), load {A_f,B_f} into prev state, go to TRACK; no step, no err, no rev_tick.
REQ-019 TRACK, forward sequence 00->10->11->01->00 ({A,B}): step=1, dir=0, pos+1.
REQ-020 TRACK, reverse sequence 00->01->11->10->00: step=1, dir=1, pos-1.
REQ-021 TRACK, 00<->11 or 01<->10: err set, no step, pos and dir unchanged, prev state updated to new value.
REQ-022 Outputs step, dir, pos, rev_tick, err SHALL be registered; a raw level change held stable SHALL raise step exactly FILT_LEN+3 cclk edges after the edge that first samples it (that edge counted as 1).
REQ-023 pos SHALL wrap modulo 2^POS_W in both directions without saturation or flag.
REQ-024 clr_pos with a simultaneous step: pos=0 (clear wins, step still pulses, dir still updates).
REQ-025 err_clr with a simultaneous illegal transition: err stays 1 (set wins).
REQ-026 rev_tick SHALL pulse on filtered A 0->1 in TRACK regardless of legality, so a downstream stage counts revolutions with B sampled as dir.

Reset
REQ-027 rstb low at a cclk edge: step=0, dir=0, rev_tick=0, pos=0, err=0, filter counters 0, synchronizers and filtered values 0, state UNINIT.
REQ-028 Reset asserted mid-transition SHALL discard any partially filtered edge; no pulse emitted on release.

Structure
REQ-029 Shared package motor_pkg SHALL hold quadrature state encodings (Q00,Q10,Q11,Q01), decoder state enum, and default FILT_LEN.
REQ-030 One sub-module, input_filter (synchronizer + glitch filter, parameter FILT_LEN), instantiated once per channel.
REQ-031 Implementation target 150-300 lines RTL total; no clocks derived from a or b.

Verification
REQ-032 Reset with a=b=1 held, release -> UNINIT loads 11, err=0, step never pulses, pos=0.
REQ-033 FILT_LEN=4, 10 full forward cycles (each level held 20 cycles) -> 40 step pulses, dir=0, pos=40, 10 rev_tick pulses; first step 7 edges after first A edge.
REQ-034 3-cycle glitch on a while b stable -> no step, pos unchanged, filtered A unchanged.
REQ-035 pos=0, one reverse transition -> pos=16'hFFFF, dir=1; then forward -> pos=0.
REQ-036 From 00, a and b toggle on the same cycle -> err=1, pos unchanged; err_clr pulse -> err=0; err_clr coincident with another illegal jump -> err=1.
REQ-037 clr_pos asserted the same cycle step pulses -> pos=0 next cycle, step observed, dir updated.
